// File: rtl/clkgen_multi.sv
// clkgen_multi: NUM_CLK independent refclk dividers with glitch-free divider updates and a lock flag.
// Define CLKGEN_PHASE_EN to add a per-channel low-time hold (cfg_phase) inserted when a new divider applies.
module clkgen_multi #(
  parameter int NUM_CLK     = 4,
  parameter int DIV_W       = 16,
  parameter int LOCK_CYCLES = 1024,
  localparam int SEL_W      = (NUM_CLK > 1) ? $clog2(NUM_CLK) : 1
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [SEL_W-1:0]   cfg_sel,
  input  logic [DIV_W-1:0]   cfg_div,
`ifdef CLKGEN_PHASE_EN
  input  logic [DIV_W-1:0]   cfg_phase,
`endif
  output logic [NUM_CLK-1:0] outclk,
  output logic               locked
);

  localparam int LCK_W = $clog2(LOCK_CYCLES + 1);

  logic [DIV_W-1:0]   cnt_q  [NUM_CLK];
  logic [DIV_W-1:0]   cnt_d  [NUM_CLK];
  logic [DIV_W-1:0]   divr_q [NUM_CLK];
  logic [DIV_W-1:0]   divr_d [NUM_CLK];
  logic [DIV_W-1:0]   pend_q [NUM_CLK];
  logic [DIV_W-1:0]   pend_d [NUM_CLK];
  logic [NUM_CLK-1:0] pend_vld_q, pend_vld_d;
  logic [NUM_CLK-1:0] out_q, out_d;
  logic [NUM_CLK-1:0] wr_hit, tick, apply, hold_act;
  logic [LCK_W-1:0]   lock_q, lock_d;
  logic               locked_q, locked_d;
  logic               wr_ok, busy;
  logic [DIV_W-1:0]   div_eff;

  assign wr_ok   = cfg_we && (32'(cfg_sel) < NUM_CLK);
  assign div_eff = (cfg_div == '0) ? DIV_W'(1) : cfg_div;

  // A pending divider only lands on a falling output edge, so every period is whole.
  always_comb begin
    wr_hit = '0;
    tick   = '0;
    apply  = '0;
    for (int i = 0; i < NUM_CLK; i++) begin
      wr_hit[i] = wr_ok && (32'(cfg_sel) == i);
      tick[i]   = !hold_act[i] && (cnt_q[i] == divr_q[i] - DIV_W'(1));
      apply[i]  = tick[i] && out_q[i] && pend_vld_q[i];
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    divr_d     = divr_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    out_d      = out_q;
    for (int i = 0; i < NUM_CLK; i++) begin
      if (tick[i]) begin
        cnt_d[i] = '0;
        out_d[i] = ~out_q[i];
      end else if (!hold_act[i]) begin
        cnt_d[i] = cnt_q[i] + DIV_W'(1);
      end
      if (apply[i]) begin
        divr_d[i]     = pend_q[i];
        pend_vld_d[i] = 1'b0;
      end
      // A write coinciding with apply becomes the next pending value.
      if (wr_hit[i]) begin
        pend_d[i]     = div_eff;
        pend_vld_d[i] = 1'b1;
      end
    end
    busy = wr_ok || (|pend_vld_q) || (|hold_act);
    if (busy) begin
      lock_d = '0;
    end else if (lock_q == LCK_W'(LOCK_CYCLES)) begin
      lock_d = lock_q;
    end else begin
      lock_d = lock_q + LCK_W'(1);
    end
    locked_d = (lock_d == LCK_W'(LOCK_CYCLES));
  end

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CLK; i++) begin
        cnt_q[i]  <= '0;
        divr_q[i] <= DIV_W'(1);
        pend_q[i] <= DIV_W'(1);
      end
      pend_vld_q <= '0;
      out_q      <= '0;
      lock_q     <= '0;
      locked_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      divr_q     <= divr_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      out_q      <= out_d;
      lock_q     <= lock_d;
      locked_q   <= locked_d;
    end
  end

`ifdef CLKGEN_PHASE_EN
  logic [DIV_W-1:0] phs_q  [NUM_CLK];
  logic [DIV_W-1:0] phs_d  [NUM_CLK];
  logic [DIV_W-1:0] hold_q [NUM_CLK];
  logic [DIV_W-1:0] hold_d [NUM_CLK];

  always_comb begin
    hold_act = '0;
    for (int i = 0; i < NUM_CLK; i++) begin
      hold_act[i] = (hold_q[i] != '0);
    end
  end

  // The hold freezes the counter with the output low before the first new half-period.
  always_comb begin
    phs_d  = phs_q;
    hold_d = hold_q;
    for (int i = 0; i < NUM_CLK; i++) begin
      if (hold_act[i]) begin
        hold_d[i] = hold_q[i] - DIV_W'(1);
      end else if (apply[i]) begin
        hold_d[i] = phs_q[i];
      end
      if (wr_hit[i]) begin
        phs_d[i] = cfg_phase;
      end
    end
  end

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CLK; i++) begin
        phs_q[i]  <= '0;
        hold_q[i] <= '0;
      end
    end else begin
      phs_q  <= phs_d;
      hold_q <= hold_d;
    end
  end
`else
  assign hold_act = '0;
`endif

  assign outclk = out_q;
  assign locked = locked_q;

endmodule

// File: tb/tb_clkgen_multi.sv
// Directed bench for clkgen_multi: a 4-channel instance plus a 6-channel instance whose 3-bit select can address absent channels.
module tb_clkgen_multi;
  localparam int NC  = 4;
  localparam int NC2 = 6;
  localparam int DW  = 16;
  localparam int LC  = 16;

  logic           refclk = 1'b0;
  logic           rst    = 1'b0;
  logic           cfg_we = 1'b0;
  logic [1:0]     cfg_sel = '0;
  logic [DW-1:0]  cfg_div = '0;
  logic [NC-1:0]  outclk;
  logic           locked;
  logic           cfg2_we = 1'b0;
  logic [2:0]     cfg2_sel = '0;
  logic [DW-1:0]  cfg2_div = '0;
  logic [NC2-1:0] outclk2;
  logic           locked2;
`ifdef CLKGEN_PHASE_EN
  logic [DW-1:0]  cfg_phase  = '0;
  logic [DW-1:0]  cfg2_phase = '0;
`endif

  int vecs   = 0;
  int miscmp = 0;
  int e      = 0;

  always #5 refclk = ~refclk;

  clkgen_multi #(.NUM_CLK(NC), .DIV_W(DW), .LOCK_CYCLES(LC)) dut (
    .refclk   (refclk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_sel  (cfg_sel),
    .cfg_div  (cfg_div),
`ifdef CLKGEN_PHASE_EN
    .cfg_phase(cfg_phase),
`endif
    .outclk   (outclk),
    .locked   (locked)
  );

  clkgen_multi #(.NUM_CLK(NC2), .DIV_W(DW), .LOCK_CYCLES(LC)) dut2 (
    .refclk   (refclk),
    .rst      (rst),
    .cfg_we   (cfg2_we),
    .cfg_sel  (cfg2_sel),
    .cfg_div  (cfg2_div),
`ifdef CLKGEN_PHASE_EN
    .cfg_phase(cfg2_phase),
`endif
    .outclk   (outclk2),
    .locked   (locked2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscmp++;
      $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, exp, e);
    end
  endtask

  // e counts refclk rising edges since reset release; samples are taken on the following falling edge.
  task automatic adv(input int n);
    repeat (n) begin
      @(negedge refclk);
      e++;
    end
  endtask

  task automatic adv_to(input int t);
    while (e < t) adv(1);
  endtask

  initial begin
    #1;
    chk("rst_out", 32'(outclk), 32'h0);
    chk("rst_lock", 32'(locked), 32'h0);
    chk("rst_out2", 32'(outclk2), 32'h0);
    repeat (2) @(negedge refclk);
    rst = 1'b1;
    e   = 0;

    // Default dividers: every channel toggles on every edge.
    adv(1);
    chk("run_e1", 32'(outclk), 32'hF);
    chk("run2_e1", 32'(outclk2), 32'h3F);
    adv(1);
    chk("run_e2", 32'(outclk), 32'h0);
    adv_to(15);
    chk("lock_e15", 32'(locked), 32'h0);
    adv(1);
    chk("lock_e16", 32'(locked), 32'h1);
    chk("lock2_e16", 32'(locked2), 32'h1);

    // Channel 2 to div 5, written while it is high.
    adv(1);
    chk("pre_w2_e17", 32'(outclk), 32'hF);
    cfg_we = 1'b1; cfg_sel = 2'd2; cfg_div = 16'd5;
    adv(1);
    cfg_we = 1'b0;
    chk("w2_e18_out", 32'(outclk), 32'h0);
    chk("w2_e18_lock", 32'(locked), 32'h0);
    adv(1);
    chk("w2_e19", 32'(outclk), 32'hF);
    adv(1);
    chk("w2_e20_apply", 32'(outclk), 32'h0);
    adv(1);
    chk("w2_e21", 32'(outclk), 32'hB);
    adv_to(24);
    chk("w2_e24", 32'(outclk), 32'h0);
    adv(1);
    chk("w2_e25", 32'(outclk), 32'hF);
    adv(1);
    chk("w2_e26", 32'(outclk), 32'h4);
    adv_to(30);
    chk("w2_e30", 32'(outclk), 32'h0);
    adv(1);
    chk("w2_e31", 32'(outclk), 32'hB);
    adv_to(35);
    chk("w2_lock_e35", 32'(locked), 32'h0);
    adv(1);
    chk("w2_lock_e36", 32'(locked), 32'h1);

    // Channel 1 written with div 0: stored as 1, so period 2 is unchanged.
    cfg_we = 1'b1; cfg_sel = 2'd1; cfg_div = 16'd0;
    adv(1);
    cfg_we = 1'b0;
    chk("d0_e37_out", 32'(outclk), 32'hF);
    chk("d0_e37_lock", 32'(locked), 32'h0);
    adv(1);
    chk("d0_e38", 32'(outclk), 32'h4);
    adv_to(41);
    chk("d0_e41", 32'(outclk), 32'hB);
    adv(1);
    chk("d0_e42", 32'(outclk), 32'h0);
    adv_to(53);
    chk("d0_lock_e53", 32'(locked), 32'h0);
    adv(1);
    chk("d0_lock_e54", 32'(locked), 32'h1);

    // Out-of-range selects on the 6-channel instance are ignored.
    cfg2_we = 1'b1; cfg2_sel = 3'd7; cfg2_div = 16'd9;
    adv(1);
    chk("oor7_out2", 32'(outclk2), 32'h3F);
    chk("oor7_lock2", 32'(locked2), 32'h1);
    cfg2_sel = 3'd6; cfg2_div = 16'd0;
    adv(1);
    cfg2_we = 1'b0;
    chk("oor6_out2", 32'(outclk2), 32'h0);
    chk("oor6_lock2", 32'(locked2), 32'h1);
    adv_to(60);
    chk("oor_e60_out2", 32'(outclk2), 32'h0);
    chk("oor_e60_lock2", 32'(locked2), 32'h1);
    chk("oor_e60_lock", 32'(locked), 32'h1);

    // Channel 0: div 3 then div 7 before the apply edge; only 7 lands.
    adv_to(61);
    cfg_we = 1'b1; cfg_sel = 2'd0; cfg_div = 16'd3;
    adv(1);
    cfg_div = 16'd7;
    adv(1);
    cfg_we = 1'b0;
    adv_to(67);
    chk("ow_e67", 32'(outclk), 32'hE);
    adv_to(70);
    chk("ow_e70", 32'(outclk), 32'h0);
    adv(1);
    chk("ow_e71", 32'(outclk), 32'hB);
    adv_to(77);
    chk("ow_e77", 32'(outclk), 32'hF);
    adv(1);
    chk("ow_e78", 32'(outclk), 32'h4);
    adv_to(79);
    chk("ow_lock_e79", 32'(locked), 32'h0);
    adv(1);
    chk("ow_lock_e80", 32'(locked), 32'h1);

    // Reset mid-reconfiguration discards the pending div 9 on channel 3.
    cfg_we = 1'b1; cfg_sel = 2'd3; cfg_div = 16'd9;
    adv(1);
    cfg_we = 1'b0;
    rst = 1'b0;
    #1;
    chk("mrst_out", 32'(outclk), 32'h0);
    chk("mrst_lock", 32'(locked), 32'h0);
    chk("mrst_out2", 32'(outclk2), 32'h0);
    chk("mrst_lock2", 32'(locked2), 32'h0);
    adv(2);
    chk("mrst_hold_out", 32'(outclk), 32'h0);
    rst = 1'b1;
    adv(1);
    chk("rel_n1", 32'(outclk), 32'hF);
    for (int n = 2; n <= 15; n++) begin
      adv(1);
      chk("rel_run", 32'(outclk), (n % 2 != 0) ? 32'hF : 32'h0);
    end
    chk("rel_lock_n15", 32'(locked), 32'h0);
    adv(1);
    chk("rel_lock_n16", 32'(locked), 32'h1);
    chk("rel_out_n16", 32'(outclk), 32'h0);

`ifdef CLKGEN_PHASE_EN
    // Channel 3 to div 4 with 3 cycles of extra low time.
    cfg_we = 1'b1; cfg_sel = 2'd3; cfg_div = 16'd4; cfg_phase = 16'd3;
    adv(1);
    cfg_we = 1'b0; cfg_phase = 16'd0;
    adv(1);
    chk("ph_e101", 32'(outclk[3]), 32'h0);
    adv_to(107);
    chk("ph_e107", 32'(outclk[3]), 32'h0);
    adv(1);
    chk("ph_e108", 32'(outclk[3]), 32'h1);
    adv_to(111);
    chk("ph_e111", 32'(outclk[3]), 32'h1);
    adv(1);
    chk("ph_e112", 32'(outclk[3]), 32'h0);
    adv_to(116);
    chk("ph_e116", 32'(outclk[3]), 32'h1);
    adv_to(119);
    chk("ph_lock_e119", 32'(locked), 32'h0);
    adv(1);
    chk("ph_lock_e120", 32'(locked), 32'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule

// File: doc/clkgen_multi.md
CLKGEN_MULTI -- requirements
Module: clkgen_multi

Interface
REQ-001 SHALL have parameter NUM_CLK, default 4, meaning the number of output clock channels (1..16).
REQ-002 SHALL have parameter DIV_W, default 16, meaning the width of the half-period divider.
REQ-003 SHALL have parameter LOCK_CYCLES, default 1024, meaning the count of stable refclk cycles required before locked asserts.
REQ-004 SHALL have port refclk  in  1  reference clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  reset; one clock, reset asynchronous and active-low (rst=0 resets).
REQ-006 SHALL have port cfg_we  in  1  one-cycle write strobe for a channel divider.
REQ-007 SHALL have port cfg_sel  in  max(1,clog2(NUM_CLK))  target channel index.
REQ-008 SHALL have port cfg_div  in  DIV_W  new half-period in refclk cycles.
REQ-009 SHALL have port cfg_phase  in  DIV_W  extra low-time inserted at apply; present only with CLKGEN_PHASE_EN.
REQ-010 SHALL have port outclk  out  NUM_CLK  registered divided clocks.
REQ-011 SHALL have port locked  out  1  all channels running at their programmed divider and stable.

Function
REQ-012 SHALL keep per channel: counter cnt, active divider divr, pending divider pend, pend_valid flag.
REQ-013 SHALL, per refclk edge with no phase hold active: if cnt==divr-1, set cnt=0 and toggle outclk[i]; else cnt=cnt+1.
REQ-014 SHALL produce an outclk period of exactly 2*divr refclk cycles with 50% duty; divr=1 gives refclk/2.
REQ-015 SHALL treat cfg_div=0 as 1 when stored.
REQ-016 SHALL, on cfg_we with cfg_sel<NUM_CLK, store cfg_div into pend[cfg_sel] and set pend_valid on the next edge.
REQ-017 SHALL ignore cfg_we when cfg_sel>=NUM_CLK (no state change, locked unaffected).
REQ-018 SHALL let a second write to a channel with pend_valid set overwrite pend (last write wins).
REQ-019 SHALL apply pend only on the edge where outclk[i] toggles 1->0: divr<=pend, cnt<=0, pend_valid<=0; no partial period or glitch is permitted.
REQ-020 SHALL, when cfg_we targets a channel on the same edge its apply occurs, apply the old pend and retain the new value as pending.
REQ-021 SHALL hold a lock counter that clears on any accepted cfg_we and while any pend_valid is set, otherwise increments, saturating at LOCK_CYCLES.
REQ-022 SHALL drive locked=1 exactly when the lock counter equals LOCK_CYCLES; locked falls on the edge after an accepted cfg_we.
REQ-023 SHALL leave channels without pending writes running undisturbed during reconfiguration of others.

Reset
REQ-024 SHALL, while rst=0, asynchronously force outclk=0, cnt=0, divr=1, pend=1, pend_valid=0, lock counter=0, locked=0.
REQ-025 SHALL, on reset asserted mid-period or mid-reconfiguration, discard all pending writes; after release every channel restarts at divr=1.
REQ-026 SHALL begin counting on the first refclk rising edge after rst deasserts.

Configuration
REQ-027 SHALL, with macro CLKGEN_PHASE_EN defined, store cfg_phase with cfg_div and, at apply, hold outclk[i] low for cfg_phase additional refclk cycles before the first new half-period.
REQ-028 SHALL, with CLKGEN_PHASE_EN defined, keep pend_valid semantics such that locked stays 0 until the phase hold has completed.
REQ-029 SHALL, without CLKGEN_PHASE_EN, omit cfg_phase and all phase storage; apply behaviour is as REQ-019 with zero hold.

Verification
REQ-030 SHALL cover reset release, no writes, NUM_CLK=4, LOCK_CYCLES=16 -> all outclk toggle every refclk edge (period 2), locked=1 on 16th edge after release.
REQ-031 SHALL cover cfg_we sel=2 div=5 while outclk[2] high -> outclk[2] finishes current high, then period 10 (5 high/5 low); locked drops next edge, reasserts 16 edges after apply.
REQ-032 SHALL cover cfg_we div=0 on channel 1 -> channel 1 stays period 2; cfg_we sel=7 with NUM_CLK=4 -> no change, locked stays 1.
REQ-033 SHALL cover two writes div=3 then div=7 to channel 0 before apply -> only 7 applied (period 14), no period of 6 observed.
REQ-034 SHALL cover rst pulsed low mid-reconfiguration with pending div=9 -> outclk=0 and locked=0 immediately; after release period 2, div 9 never appears.
REQ-035 SHALL cover CLKGEN_PHASE_EN, div=4 phase=3 on channel 3 -> after 1->0 apply, low time 3+4=7 cycles, then period 8.
